// File: rtl/uci_info_formatter_pkg.sv
// Shared types and constants for the UCI info-line formatter: move encoding,
// snapshot record, label strings and small character helpers.
package uci_info_formatter_pkg;

  typedef enum logic [2:0] {
    SPECIAL_NONE,
    SPECIAL_PROMOTE_KNIGHT,
    SPECIAL_PROMOTE_BISHOP,
    SPECIAL_PROMOTE_ROOK,
    SPECIAL_PROMOTE_QUEEN,
    SPECIAL_CASTLE,
    SPECIAL_EN_PASSANT,
    SPECIAL_DOUBLE_PUSH
  } special_t;

  typedef struct packed {
    logic [2:0] fil;
    logic [2:0] rnk;
  } square_t;

  typedef struct packed {
    square_t  src;
    square_t  dst;
    special_t special;
  } move_t;

  typedef struct packed {
    logic [7:0]  depth;
    logic [15:0] score;
    logic        mate;
    logic [31:0] nodes;
    move_t       move;
  } snap_t;

  typedef logic [9:0][3:0] bcd_t;

  localparam int INFO_MAX_CHARS = 51;
  localparam int LBL_W          = 96;

  // Labels are right-aligned in a 12-byte field; the first character sits at byte LEN-1
  localparam logic [LBL_W-1:0] STR_DEPTH      = {48'h0, "depth "};
  localparam logic [LBL_W-1:0] STR_SCORE_CP   = {16'h0, " score cp "};
  localparam logic [LBL_W-1:0] STR_SCORE_MATE = " score mate ";
  localparam logic [LBL_W-1:0] STR_NODES      = {40'h0, " nodes "};
  localparam logic [LBL_W-1:0] STR_PV         = {64'h0, " pv "};

  localparam logic [3:0] LEN_DEPTH      = 4'd6;
  localparam logic [3:0] LEN_SCORE_CP   = 4'd10;
  localparam logic [3:0] LEN_SCORE_MATE = 4'd12;
  localparam logic [3:0] LEN_NODES      = 4'd7;
  localparam logic [3:0] LEN_PV         = 4'd4;

  typedef enum logic [3:0] {
    SEG_DEPTH_LBL,
    SEG_DEPTH_NUM,
    SEG_SCORE_LBL,
    SEG_SIGN,
    SEG_SCORE_NUM,
    SEG_NODES_LBL,
    SEG_NODES_NUM,
    SEG_PV_LBL,
    SEG_MOVE,
    SEG_DONE
  } seg_t;

  function automatic logic [7:0] lbl_char(input logic [LBL_W-1:0] s,
                                          input logic [3:0] len,
                                          input logic [3:0] idx);
    logic [3:0]       pos;
    logic [LBL_W-1:0] t;
    pos = len - idx - 4'd1;
    t   = s >> {pos, 3'b000};
    return t[7:0];
  endfunction

  function automatic logic [7:0] promo_char(input special_t sp);
    case (sp)
      SPECIAL_PROMOTE_KNIGHT: return "n";
      SPECIAL_PROMOTE_BISHOP: return "b";
      SPECIAL_PROMOTE_ROOK:   return "r";
      SPECIAL_PROMOTE_QUEEN:  return "q";
      default:                return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/uci_info_formatter_bin_to_bcd32.sv
// bin_to_bcd32: sequential double-dabble, one input bit per cycle. The first
// bit is consumed on the start edge, so done pulses exactly 32 edges in.
module bin_to_bcd32
  import uci_info_formatter_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start,
  input  logic [31:0] bin_in,
  output logic        busy,
  output logic        done,
  output bcd_t        bcd_out
);

  logic [31:0] shreg;
  logic [4:0]  cnt;

  function automatic bcd_t dd_step(input bcd_t b, input logic bit_in);
    bcd_t        a;
    logic [40:0] t;
    for (int i = 0; i < 10; i++) begin
      a[i] = (b[i] >= 4'd5) ? b[i] + 4'd3 : b[i];
    end
    t = {a, bit_in};
    return t[39:0];
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= 5'd0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        bcd_out <= dd_step('0, bin_in[31]);
        shreg   <= {bin_in[30:0], 1'b0};
        cnt     <= 5'd30;
        busy    <= 1'b1;
      end else if (busy) begin
        bcd_out <= dd_step(bcd_out, shreg[31]);
        shreg   <= {shreg[30:0], 1'b0};
        cnt     <= cnt - 5'd1;
        if (cnt == 5'd0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uci_info_formatter.sv
// uci_info_formatter: turns a search-stats snapshot into the ASCII "info" payload.
// Define UCI_INFO_COALESCE_EN to accept snapshots while busy (latest one wins).
module uci_info_formatter
  import uci_info_formatter_pkg::*;
#(
  parameter int INFO_LEN = 52
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      stats_valid,
  output logic                      stats_ready,
  input  logic [7:0]                depth_in,
  input  logic signed [15:0]        score_in,
  input  logic                      score_is_mate_in,
  input  logic [31:0]               nodes_in,
  input  move_t                     pv_move_in,
  output logic [INFO_LEN-1:0][7:0]  info_out,
  output logic                      info_out_valid,
  input  logic                      info_out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_BUILD, S_HOLD} state_t;

  state_t      state;
  snap_t       snap;
  snap_t       live;
  logic [1:0]  conv_idx;
  bcd_t        depth_bcd, score_bcd, nodes_bcd;
  seg_t        seg, seg_nxt;
  logic [3:0]  sub, seg_len;
  logic [5:0]  wr_ptr;
  logic [7:0]  ch, promo;
  logic [3:0]  depth_nd, score_nd, nodes_nd;
  logic        seg_end, last_char, null_mv;

  logic        cv_start, cv_busy, cv_done;
  logic [31:0] cv_bin;
  bcd_t        cv_bcd;

  function automatic logic [16:0] abs17(input logic [15:0] v);
    logic signed [16:0] s;
    s = {v[15], v};
    return s[16] ? $unsigned(-s) : $unsigned(s);
  endfunction

  function automatic logic [3:0] bcd_ndig(input bcd_t b);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 1; i < 10; i++) begin
      if (b[i] != 4'd0) n = 4'(i + 1);
    end
    return n;
  endfunction

  function automatic logic [7:0] dig_char(input bcd_t b, input logic [3:0] idx);
    return 8'h30 + {4'h0, b[idx]};
  endfunction

  assign live     = {depth_in, score_in, score_is_mate_in, nodes_in, pv_move_in};
  assign depth_nd = bcd_ndig(depth_bcd);
  assign score_nd = bcd_ndig(score_bcd);
  assign nodes_nd = bcd_ndig(nodes_bcd);
  assign null_mv  = (snap.move.src == snap.move.dst);
  assign promo    = promo_char(snap.move.special);

  // One converter serves depth, |score| and nodes back to back; a new start
  // is issued in the same cycle the previous result is reported.
  assign cv_start = (state == S_CONV) && !cv_busy && (conv_idx != 2'd3);

  always_comb begin
    case (conv_idx)
      2'd0:    cv_bin = {24'd0, snap.depth};
      2'd1:    cv_bin = {15'd0, abs17(snap.score)};
      default: cv_bin = snap.nodes;
    endcase
  end

  bin_to_bcd32 u_bcd (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .start   (cv_start),
    .bin_in  (cv_bin),
    .busy    (cv_busy),
    .done    (cv_done),
    .bcd_out (cv_bcd)
  );

  always_comb begin
    ch      = 8'h00;
    seg_len = 4'd1;
    seg_nxt = SEG_DONE;
    case (seg)
      SEG_DEPTH_LBL: begin
        ch      = lbl_char(STR_DEPTH, LEN_DEPTH, sub);
        seg_len = LEN_DEPTH;
        seg_nxt = SEG_DEPTH_NUM;
      end
      SEG_DEPTH_NUM: begin
        ch      = dig_char(depth_bcd, depth_nd - sub - 4'd1);
        seg_len = depth_nd;
        seg_nxt = SEG_SCORE_LBL;
      end
      SEG_SCORE_LBL: begin
        if (snap.mate) begin
          ch      = lbl_char(STR_SCORE_MATE, LEN_SCORE_MATE, sub);
          seg_len = LEN_SCORE_MATE;
        end else begin
          ch      = lbl_char(STR_SCORE_CP, LEN_SCORE_CP, sub);
          seg_len = LEN_SCORE_CP;
        end
        seg_nxt = snap.score[15] ? SEG_SIGN : SEG_SCORE_NUM;
      end
      SEG_SIGN: begin
        ch      = "-";
        seg_nxt = SEG_SCORE_NUM;
      end
      SEG_SCORE_NUM: begin
        ch      = dig_char(score_bcd, score_nd - sub - 4'd1);
        seg_len = score_nd;
        seg_nxt = SEG_NODES_LBL;
      end
      SEG_NODES_LBL: begin
        ch      = lbl_char(STR_NODES, LEN_NODES, sub);
        seg_len = LEN_NODES;
        seg_nxt = SEG_NODES_NUM;
      end
      SEG_NODES_NUM: begin
        ch      = dig_char(nodes_bcd, nodes_nd - sub - 4'd1);
        seg_len = nodes_nd;
        seg_nxt = null_mv ? SEG_DONE : SEG_PV_LBL;
      end
      SEG_PV_LBL: begin
        ch      = lbl_char(STR_PV, LEN_PV, sub);
        seg_len = LEN_PV;
        seg_nxt = SEG_MOVE;
      end
      SEG_MOVE: begin
        seg_len = (promo != 8'h00) ? 4'd5 : 4'd4;
        case (sub)
          4'd0:    ch = 8'h61 + {5'd0, snap.move.src.fil};
          4'd1:    ch = 8'h31 + {5'd0, snap.move.src.rnk};
          4'd2:    ch = 8'h61 + {5'd0, snap.move.dst.fil};
          4'd3:    ch = 8'h31 + {5'd0, snap.move.dst.rnk};
          default: ch = promo;
        endcase
      end
      default: ;
    endcase
  end

  assign seg_end   = (sub == seg_len - 4'd1);
  assign last_char = seg_end && (seg_nxt == SEG_DONE);

`ifdef UCI_INFO_COALESCE_EN
  logic  pend;
  snap_t pend_snap;
  logic  hold_hs;

  assign stats_ready = 1'b1;
  assign hold_hs     = (state == S_HOLD) && info_out_ready;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pend <= 1'b0;
    end else if (hold_hs) begin
      pend <= 1'b0;
    end else if (stats_valid && (state != S_IDLE)) begin
      pend      <= 1'b1;
      pend_snap <= live;
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      info_out       <= '0;
      info_out_valid <= 1'b0;
      conv_idx       <= 2'd0;
      seg            <= SEG_DEPTH_LBL;
      sub            <= 4'd0;
      wr_ptr         <= 6'd0;
`ifndef UCI_INFO_COALESCE_EN
      stats_ready    <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (stats_valid) begin
            snap     <= live;
            conv_idx <= 2'd0;
            state    <= S_CONV;
`ifndef UCI_INFO_COALESCE_EN
            stats_ready <= 1'b0;
`endif
          end
        end
        S_CONV: begin
          if (cv_start) conv_idx <= conv_idx + 2'd1;
          if (cv_done) begin
            case (conv_idx)
              2'd1: depth_bcd <= cv_bcd;
              2'd2: score_bcd <= cv_bcd;
              default: begin
                nodes_bcd <= cv_bcd;
                seg       <= SEG_DEPTH_LBL;
                sub       <= 4'd0;
                wr_ptr    <= 6'd0;
                state     <= S_BUILD;
              end
            endcase
          end
        end
        S_BUILD: begin
          info_out[wr_ptr] <= ch;
          wr_ptr           <= wr_ptr + 6'd1;
          if (seg_end) begin
            seg <= seg_nxt;
            sub <= 4'd0;
          end else begin
            sub <= sub + 4'd1;
          end
          if (last_char) begin
            info_out_valid <= 1'b1;
            state          <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (info_out_ready) begin
            info_out_valid <= 1'b0;
            info_out       <= '0;
            state          <= S_IDLE;
`ifdef UCI_INFO_COALESCE_EN
            if (pend || stats_valid) begin
              snap     <= stats_valid ? live : pend_snap;
              conv_idx <= 2'd0;
              state    <= S_CONV;
            end
`else
            stats_ready <= 1'b1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uci_info_formatter.md
Name: uci_info_formatter

Overview:
Converts a search-statistics snapshot (depth, score, node count, principal move) into the ASCII payload of a UCI "info" line. It sits directly upstream of the UCI handler's info_in/info_in_valid/info_in_ready port. The handler prefixes "info " and appends the newline. Binary-to-decimal conversion is sequential (double-dabble), and string assembly runs one character per cycle.

Parameters:
INFO_LEN, 52, payload width in bytes; must equal the downstream handler's INFO_LEN; minimum 52 (worst-case line is 51 chars).

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous, active-high reset
stats_valid  input  1  snapshot valid
stats_ready  output  1  snapshot accept
depth_in  input  8  search depth, unsigned
score_in  input  16  signed; centipawns, or moves-to-mate when score_is_mate_in=1
score_is_mate_in  input  1  selects "mate" vs "cp"
nodes_in  input  32  node count, unsigned
pv_move_in  input  move_t  best move so far; src==dst means null
info_out  output  [INFO_LEN-1:0][7:0]  payload; byte 0 is the first character; zero-padded after the last character
info_out_valid  output  1  payload valid
info_out_ready  input  1  downstream accept

Behaviour:
- Reset, all outputs: info_out=0, info_out_valid=0, stats_ready=1, FSM=IDLE. Reset mid-operation abandons the snapshot with no partial output.
- Format: "depth D score cp S nodes N pv MMMM[p]".
  - Mate replaces "cp" with "mate".
  - The " pv ..." field is omitted for a null move.
- Decimal rules:
  - No leading zeros; value 0 prints "0".
  - Negative score prints "-" then the magnitude. Magnitude uses a 17-bit abs, so -32768 prints "-32768".
- Move text: file = "a"+fil, rank = "1"+rnk, for src then dst. Promotion suffix: n/b/r/q for SPECIAL_PROMOTE_*; no suffix otherwise.
- FSM states:
  - IDLE: stats_ready=1. On stats_valid&&stats_ready at edge k, latch all inputs and go to CONV.
  - CONV: one shared 32-bit double-dabble converter, one bit per cycle, 32 cycles per number. Order is depth, |score|, nodes (zero-extended), 96 cycles total (k+1..k+96). Results go into three 10-digit BCD registers.
  - BUILD: appends one character per cycle at a write pointer into a zeroed buffer. Takes L cycles, where L = string length.
  - HOLD: info_out_valid=1 and info_out stable. On info_out_ready the buffer is cleared next cycle and the FSM returns to IDLE.
- Latency: info_out_valid first asserts at edge k+97+L. The next snapshot is accepted no earlier than the cycle after the handshake.
- stats_ready=0 in CONV/BUILD/HOLD unless UCI_INFO_COALESCE_EN is defined.
- The write pointer never exceeds 51. No overflow handling is needed because INFO_LEN>=52.
- info_out_valid&&info_out_ready in the same cycle as reset: reset wins.

Optional Feature:
UCI_INFO_COALESCE_EN
- Defined:
  - stats_ready is constantly 1. Snapshots arriving while busy overwrite a single pending register (latest wins) and set pending.
  - After the HOLD handshake, a set pending flag starts CONV on the next cycle using the pending data, bypassing IDLE.
  - A snapshot arriving in the same cycle as the HOLD handshake is still captured as pending.
- Undefined: no pending register; stats_ready=1 only in IDLE.

Decomposition:
- Shared package (existing types package): move_t, SPECIAL_* enum (already present).
- New package entries: character constants for " pv ", "depth ", " score cp ", " score mate ", " nodes "; constant INFO_MAX_CHARS=51.
- One sub-module: bin_to_bcd32 (start/busy/done, 32-bit in, 10×4-bit BCD out, 32-cycle fixed latency). It is instantiated once and time-shared.

Test Plan:
- depth=5, score=34 cp, nodes=1234, pv e2e4 (src(4,1) dst(4,3), SPECIAL_NONE) -> "depth 5 score cp 34 nodes 1234 pv e2e4", L=38, valid at k+135, bytes 38..51 = 0.
- depth=255, score=-32768 cp, nodes=4294967295, pv e7e8 SPECIAL_PROMOTE_QUEEN -> "depth 255 score cp -32768 nodes 4294967295 pv e7e8q", L=51, byte 51 = 0.
- depth=12, score_is_mate=1, score=-3, nodes=0, null move (src==dst) -> "depth 12 score mate -3 nodes 0", no pv field, L=30.
- Hold info_out_ready=0 for 50 cycles -> info_out_valid and info_out stable and stats_ready=0 throughout. Then ready=1 for one cycle -> valid=0 the next cycle.
- Assert rst_in at k+50 mid-CONV -> outputs return to reset values the next cycle. A fresh snapshot afterwards produces correct output with normal latency.
- UCI_INFO_COALESCE_EN: send snapshots A, B, C while A is converting -> output A, then C. B is never emitted, and stats_ready stays 1.
